// File: rtl/sat_round_scaler.sv
// Rounds (half toward +inf) and saturates complex multiplier products per lane, with frame start/end tagging.
// Latency: 2 cycles from accepted block to out_valid. No backpressure: one block per cycle, always accepted.
// Define SAT_ROUND_SCALER_SAT_CNT_EN to add the sticky 16-bit sat_count block statistic.
module sat_round_scaler #(
  parameter int NUM_PARALLEL_PATHS = 16,
  parameter int DATA_IN_WIDTH      = 25,
  parameter int DATA_OUT_WIDTH     = 13,
  parameter int SHIFT              = 7,
  parameter int FRAME_BLOCKS       = 32
) (
  input  logic                                                      clk,
  input  logic                                                      rstn,
  input  logic                                                      in_valid,
  input  logic signed [0:NUM_PARALLEL_PATHS-1][DATA_IN_WIDTH-1:0]   in_re,
  input  logic signed [0:NUM_PARALLEL_PATHS-1][DATA_IN_WIDTH-1:0]   in_im,
  output logic                                                      out_valid,
  output logic signed [0:NUM_PARALLEL_PATHS-1][DATA_OUT_WIDTH-1:0]  out_re,
  output logic signed [0:NUM_PARALLEL_PATHS-1][DATA_OUT_WIDTH-1:0]  out_im,
  output logic                                                      out_frame_start,
  output logic                                                      out_frame_end,
  output logic                                                      sat_flag
`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
  ,
  output logic [15:0]                                               sat_count
`endif
);

  localparam int NL    = NUM_PARALLEL_PATHS;
  localparam int DO    = DATA_OUT_WIDTH;
  localparam int RW    = DATA_IN_WIDTH + 1;
  localparam int CNT_W = (FRAME_BLOCKS > 1) ? $clog2(FRAME_BLOCKS) : 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FRAME_BLOCKS - 1);
  localparam logic signed [RW-1:0] RND_BIAS = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0] R_MAX    = {{(RW-DO+1){1'b0}}, {(DO-1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN    = {{(RW-DO+1){1'b1}}, {(DO-1){1'b0}}};
  localparam logic [DO-1:0]        O_MAX    = {1'b0, {(DO-1){1'b1}}};
  localparam logic [DO-1:0]        O_MIN    = {1'b1, {(DO-1){1'b0}}};

  // One guard bit keeps the bias addition from overflowing at the positive rail.
  function automatic logic signed [RW-1:0] round_shift(input logic [DATA_IN_WIDTH-1:0] x);
    logic signed [RW-1:0] xe;
    xe = $signed({x[DATA_IN_WIDTH-1], x});
    xe = xe + RND_BIAS;
    return xe >>> SHIFT;
  endfunction

  // Returns {saturated, clamped sample}.
  function automatic logic [DO:0] clamp(input logic signed [RW-1:0] r);
    if (r > R_MAX)
      return {1'b1, O_MAX};
    else if (r < R_MIN)
      return {1'b1, O_MIN};
    else
      return {1'b0, r[DO-1:0]};
  endfunction

  logic [CNT_W-1:0]     blk_cnt;
  logic                 v1;
  logic                 fs1;
  logic                 fe1;
  logic signed [RW-1:0] s1_re [NL];
  logic signed [RW-1:0] s1_im [NL];
  logic signed [RW-1:0] rnd_re [NL];
  logic signed [RW-1:0] rnd_im [NL];
  logic [DO:0]          cl_re [NL];
  logic [DO:0]          cl_im [NL];
  logic                 sat_any;

  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < NL; i++) begin
      rnd_re[i] = round_shift(in_re[i]);
      rnd_im[i] = round_shift(in_im[i]);
      cl_re[i]  = clamp(s1_re[i]);
      cl_im[i]  = clamp(s1_im[i]);
      sat_any   = sat_any | cl_re[i][DO] | cl_im[i][DO];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt         <= '0;
      v1              <= 1'b0;
      fs1             <= 1'b0;
      fe1             <= 1'b0;
      out_valid       <= 1'b0;
      out_frame_start <= 1'b0;
      out_frame_end   <= 1'b0;
      sat_flag        <= 1'b0;
      out_re          <= '0;
      out_im          <= '0;
      for (int i = 0; i < NL; i++) begin
        s1_re[i] <= '0;
        s1_im[i] <= '0;
      end
    end else begin
      // Frame tags ride the valid pipeline so they are never seen without out_valid.
      v1              <= in_valid;
      fs1             <= in_valid && (blk_cnt == '0);
      fe1             <= in_valid && (blk_cnt == CNT_LAST);
      out_valid       <= v1;
      out_frame_start <= fs1;
      out_frame_end   <= fe1;
      if (in_valid) begin
        blk_cnt <= (blk_cnt == CNT_LAST) ? '0 : blk_cnt + CNT_W'(1);
        for (int i = 0; i < NL; i++) begin
          s1_re[i] <= rnd_re[i];
          s1_im[i] <= rnd_im[i];
        end
      end
      if (v1) begin
        sat_flag <= sat_any;
        for (int i = 0; i < NL; i++) begin
          out_re[i] <= cl_re[i][DO-1:0];
          out_im[i] <= cl_im[i][DO-1:0];
        end
      end
    end
  end

`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
  // Counts blocks, not lanes, and sticks at full scale.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_count <= '0;
    else if (v1 && sat_any && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sat_round_scaler.sv
// Directed bench for sat_round_scaler: rounding, saturation, hold, framing, mid-frame reset.
module tb_sat_round_scaler;
  localparam int NL = 16;
  localparam int DI = 25;
  localparam int DO = 13;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          in_valid;
  logic signed [0:NL-1][DI-1:0]  in_re;
  logic signed [0:NL-1][DI-1:0]  in_im;
  logic                          out_valid;
  logic signed [0:NL-1][DO-1:0]  out_re;
  logic signed [0:NL-1][DO-1:0]  out_im;
  logic                          out_frame_start;
  logic                          out_frame_end;
  logic                          sat_flag;
`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
  logic [15:0]                   sat_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int nout;

  sat_round_scaler dut (
    .clk             (clk),
    .rstn            (rstn),
    .in_valid        (in_valid),
    .in_re           (in_re),
    .in_im           (in_im),
    .out_valid       (out_valid),
    .out_re          (out_re),
    .out_im          (out_im),
    .out_frame_start (out_frame_start),
    .out_frame_end   (out_frame_end),
    .sat_flag        (sat_flag)
`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
    ,
    .sat_count       (sat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  function automatic longint ore(input int i);
    logic signed [DO-1:0] v;
    v = out_re[i];
    return longint'(v);
  endfunction

  function automatic longint oim(input int i);
    logic signed [DO-1:0] v;
    v = out_im[i];
    return longint'(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rin  [5];
    int rexp [5];
    rin  = '{128, 64, -64, -65, 191};
    rexp = '{1, 1, 0, -1, 1};

    rstn = 1'b0;
    clr_in();
    repeat (2) tick();
    chk("rst_vld", out_valid, 0);
    chk("rst_fs", out_frame_start, 0);
    chk("rst_fe", out_frame_end, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_re0", ore(0), 0);
`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
    chk("rst_cnt", sat_count, 0);
`endif
    rstn = 1'b1;
    tick();

    // Rounding vectors in lanes 0..4, negated on the imaginary side.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_re[i] = DI'(rin[i]);
      in_im[i] = DI'(-rin[i]);
    end
    tick();
    clr_in();
    chk("lat1_vld", out_valid, 0);
    tick();
    chk("rnd_vld", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rnd_re%0d", i), ore(i), rexp[i]);
    end
    chk("rnd_im0", oim(0), -1);
    chk("rnd_im1", oim(1), 0);
    chk("rnd_im3", oim(3), 1);
    chk("rnd_im4", oim(4), -1);
    chk("rnd_sat", sat_flag, 0);
    chk("rnd_fs", out_frame_start, 1);
    chk("rnd_fe", out_frame_end, 0);

    // Saturation at both rails in lane 5.
    in_valid = 1'b1;
    in_re[5] = DI'((2**24) - 1);
    in_im[5] = DI'(-(2**24));
    tick();
    clr_in();
    tick();
    chk("sat_vld", out_valid, 1);
    chk("sat_re5", ore(5), 4095);
    chk("sat_im5", oim(5), -4096);
    chk("sat_re0", ore(0), 0);
    chk("sat_flag", sat_flag, 1);
    chk("sat_fs", out_frame_start, 0);
`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
    chk("sat_cnt1", sat_count, 1);
`endif

    // Idle cycles must hold the last block.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_vld", out_valid, 0);
      chk("hold_re5", ore(5), 4095);
      chk("hold_im5", oim(5), -4096);
      chk("hold_sat", sat_flag, 1);
      chk("hold_fs", out_frame_start, 0);
    end

    // Framing: 64 blocks, random gaps, lane 0 carries the block index.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    nout = 0;
    fork
      begin
        for (int b = 0; b < 64; b++) begin
          in_valid = 1'b1;
          in_re[0] = DI'(b * 128);
          in_im[0] = DI'(-b * 128);
          tick();
          clr_in();
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        repeat (300) begin
          tick();
          if (out_valid) begin
            chk("frm_fs", out_frame_start, longint'(nout % 32 == 0));
            chk("frm_fe", out_frame_end, longint'(nout % 32 == 31));
            chk("frm_re0", ore(0), nout);
            chk("frm_im0", oim(0), -nout);
            nout++;
          end else begin
            chk("gap_fs", out_frame_start, 0);
            chk("gap_fe", out_frame_end, 0);
          end
        end
      end
    join
    chk("frm_nout", nout, 64);

    // Reset after block 10 of a frame.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int b = 0; b <= 10; b++) begin
      in_valid = 1'b1;
      in_re[0] = DI'((b + 1) * 128);
      tick();
    end
    clr_in();
    rstn = 1'b0;
    #2;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_re0", ore(0), 0);
    chk("mrst_fs", out_frame_start, 0);
    chk("mrst_fe", out_frame_end, 0);
    chk("mrst_sat", sat_flag, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("mrst_flush", out_valid, 0);
    in_valid = 1'b1;
    in_re[0] = DI'(5 * 128);
    tick();
    clr_in();
    tick();
    chk("mrst_nvld", out_valid, 1);
    chk("mrst_nfs", out_frame_start, 1);
    chk("mrst_nfe", out_frame_end, 0);
    chk("mrst_nre0", ore(0), 5);

`ifdef SAT_ROUND_SCALER_SAT_CNT_EN
    // Counter must stick at full scale rather than wrap.
    in_valid = 1'b1;
    in_re[0] = DI'((2**24) - 1);
    repeat (70000) tick();
    clr_in();
    repeat (3) tick();
    chk("cnt_stick", sat_count, 65535);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
